// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the user-mode trap sequencer: cause codes, CSR addresses,
// FSM state encoding and the tval source select produced by the priority encoder.
package trap_sequencer_pkg;

  localparam int CAUSE_W = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_MISFETCH = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_MISLOAD  = 4'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_MISSTORE = 4'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL    = 4'd8;

  localparam logic [11:0] CSR_UTVEC  = 12'h005;
  localparam logic [11:0] CSR_UEPC   = 12'h041;
  localparam logic [11:0] CSR_UCAUSE = 12'h042;
  localparam logic [11:0] CSR_UTVAL  = 12'h043;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_TVAL   = 3'd3,
    ST_TRAP_JMP = 3'd4,
    ST_RET_JMP  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TV_ZERO = 2'd0,
    TV_PC   = 2'd1,
    TV_INST = 2'd2,
    TV_ADDR = 2'd3
  } tval_sel_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// Commit-stage / CSR-file / fetch-redirect signal bundle around the trap sequencer.
interface trap_sequencer_if #(
  parameter int XLEN = 32,
  parameter int CSRW = 12
);
  logic            iValid;
  logic [XLEN-1:0] iPC;
  logic [31:0]     iInst;
  logic [XLEN-1:0] iAddr;
  logic            iMisFetch;
  logic            iIllegal;
  logic            iEcall;
  logic            iMisLoad;
  logic            iMisStore;
  logic            iUret;
  logic [XLEN-1:0] iUTVEC;
  logic [XLEN-1:0] iUEPC;
  logic            oStall;
  logic            oCSRWe;
  logic [CSRW-1:0] oCSRAddr;
  logic [XLEN-1:0] oCSRWData;
  logic            oRedirect;
  logic [XLEN-1:0] oRedirectPC;
  logic            oBusy;

  modport master (
    output iValid, iPC, iInst, iAddr, iMisFetch, iIllegal, iEcall, iMisLoad, iMisStore,
           iUret, iUTVEC, iUEPC,
    input  oStall, oCSRWe, oCSRAddr, oCSRWData, oRedirect, oRedirectPC, oBusy
  );

  modport slave (
    input  iValid, iPC, iInst, iAddr, iMisFetch, iIllegal, iEcall, iMisLoad, iMisStore,
           iUret, iUTVEC, iUEPC,
    output oStall, oCSRWe, oCSRAddr, oCSRWData, oRedirect, oRedirectPC, oBusy
  );
endinterface

// File: rtl/trap_priority_enc.sv
// Combinational exception priority encoder: picks the winning flag and reports
// its cause code and which commit-stage value becomes tval.
module trap_priority_enc
  import trap_sequencer_pkg::*;
(
  input  logic               valid,
  input  logic               mis_fetch,
  input  logic               illegal,
  input  logic               ecall,
  input  logic               mis_load,
  input  logic               mis_store,
  output logic               exc_vld,
  output logic [CAUSE_W-1:0] cause,
  output tval_sel_e          tval_sel
);

  always_comb begin
    exc_vld  = 1'b0;
    cause    = '0;
    tval_sel = TV_ZERO;
    if (valid) begin
      // Store outranks load when both misalign on the same instruction.
      if (mis_fetch) begin
        exc_vld = 1'b1; cause = CAUSE_MISFETCH; tval_sel = TV_PC;
      end else if (illegal) begin
        exc_vld = 1'b1; cause = CAUSE_ILLEGAL;  tval_sel = TV_INST;
      end else if (ecall) begin
        exc_vld = 1'b1; cause = CAUSE_ECALL;    tval_sel = TV_ZERO;
      end else if (mis_store) begin
        exc_vld = 1'b1; cause = CAUSE_MISSTORE; tval_sel = TV_ADDR;
      end else if (mis_load) begin
        exc_vld = 1'b1; cause = CAUSE_MISLOAD;  tval_sel = TV_ADDR;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Synchronous-exception front end: latches the trapping instruction, writes
// uepc/ucause/utval in sequence, then redirects fetch to utvec; uret jumps to uepc.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CSRW = 12
) (
  input logic             iCLK,
  input logic             iRST,
  trap_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    tval_q, tval_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  logic               exc_vld;
  logic [CAUSE_W-1:0] enc_cause;
  tval_sel_e          enc_sel;
  logic [XLEN-1:0]    tval_src;

  logic               stall, csr_we, redirect;
  logic [CSRW-1:0]    csr_addr;
  logic [XLEN-1:0]    csr_wdata, redirect_pc;

  trap_priority_enc u_enc (
    .valid     (bus.iValid),
    .mis_fetch (bus.iMisFetch),
    .illegal   (bus.iIllegal),
    .ecall     (bus.iEcall),
    .mis_load  (bus.iMisLoad),
    .mis_store (bus.iMisStore),
    .exc_vld   (exc_vld),
    .cause     (enc_cause),
    .tval_sel  (enc_sel)
  );

  always_comb begin
    tval_src = '0;
    unique case (enc_sel)
      TV_PC:   tval_src = bus.iPC;
      TV_INST: tval_src = XLEN'(bus.iInst);
      TV_ADDR: tval_src = bus.iAddr;
      default: tval_src = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    tval_d      = tval_q;
    stall       = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Acceptance is suppressed under reset so the stall stays low with it.
        if (!iRST && exc_vld) begin
          stall   = 1'b1;
          pc_d    = bus.iPC;
          cause_d = enc_cause;
          tval_d  = tval_src;
          state_d = ST_W_EPC;
        end else if (!iRST && bus.iValid && bus.iUret) begin
          stall   = 1'b1;
          state_d = ST_RET_JMP;
        end
      end
      ST_W_EPC: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSRW'(CSR_UEPC);
        csr_wdata = pc_q;
        state_d   = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSRW'(CSR_UCAUSE);
        csr_wdata = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
        state_d   = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSRW'(CSR_UTVAL);
        csr_wdata = tval_q;
        state_d   = ST_TRAP_JMP;
      end
      ST_TRAP_JMP: begin
        redirect    = 1'b1;
        redirect_pc = {bus.iUTVEC[XLEN-1:2], 2'b00};
        state_d     = ST_IDLE;
      end
      ST_RET_JMP: begin
        redirect    = 1'b1;
        redirect_pc = bus.iUEPC;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  assign bus.oStall      = stall;
  assign bus.oCSRWe      = csr_we;
  assign bus.oCSRAddr    = csr_addr;
  assign bus.oCSRWData   = csr_wdata;
  assign bus.oRedirect   = redirect;
  assign bus.oRedirectPC = redirect_pc;
  assign bus.oBusy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: expected CSR writes and redirects are
// queued with their cycle stamps and matched against what the DUT emits.
module tb_trap_sequencer;

  typedef struct packed {
    logic        kind;   // 0 = CSR write, 1 = redirect
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = '0;
  int          n_pass = 0;
  int          n_total = 0;
  int          viol = 0;
  int          we_run = 0;
  int          rd_run = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trap_sequencer_if #(.XLEN(32), .CSRW(12)) bus ();

  trap_sequencer #(.XLEN(32), .CSRW(12)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  function automatic ev_t mk_ev(input logic k, input logic [11:0] a, input logic [31:0] d,
                                input logic [31:0] c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    return e;
  endfunction

  // Output monitor plus protocol invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oCSRWe)    obs_q.push_back(mk_ev(1'b0, bus.oCSRAddr, bus.oCSRWData, cyc));
      if (bus.oRedirect) obs_q.push_back(mk_ev(1'b1, 12'h000, bus.oRedirectPC, cyc));
      if (!bus.oCSRWe && (bus.oCSRAddr !== 12'h0 || bus.oCSRWData !== 32'h0)) viol++;
      if (!bus.oRedirect && bus.oRedirectPC !== 32'h0) viol++;
      we_run = bus.oCSRWe ? we_run + 1 : 0;
      rd_run = bus.oRedirect ? rd_run + 1 : 0;
      if (we_run > 3) viol++;
      if (rd_run > 1) viol++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    bus.iValid = 0; bus.iPC = 0; bus.iInst = 0; bus.iAddr = 0;
    bus.iMisFetch = 0; bus.iIllegal = 0; bus.iEcall = 0; bus.iMisLoad = 0;
    bus.iMisStore = 0; bus.iUret = 0;
  endtask

  // flags = {misfetch, illegal, ecall, misload, misstore}
  task automatic accept(input logic [4:0] fl, input logic uret, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [31:0] addr,
                        output logic [31:0] c0, output logic stall0);
    @(posedge clk); #1;
    bus.iValid = 1; bus.iPC = pc; bus.iInst = inst; bus.iAddr = addr;
    bus.iMisFetch = fl[4]; bus.iIllegal = fl[3]; bus.iEcall = fl[2];
    bus.iMisLoad = fl[1]; bus.iMisStore = fl[0]; bus.iUret = uret;
    @(negedge clk);
    c0 = cyc;
    stall0 = bus.oStall;
  endtask

  task automatic push_trap(input logic [31:0] c0, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] target);
    exp_q.push_back(mk_ev(1'b0, 12'h041, pc,    c0 + 1));
    exp_q.push_back(mk_ev(1'b0, 12'h042, cause, c0 + 2));
    exp_q.push_back(mk_ev(1'b0, 12'h043, tval,  c0 + 3));
    exp_q.push_back(mk_ev(1'b1, 12'h000, target, c0 + 4));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.oBusy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1; clear_in(); bus.iUTVEC = 0; bus.iUEPC = 0;
    repeat (3) @(posedge clk);
    #1; bus.iValid = 1; bus.iIllegal = 1; bus.iUret = 1;
    @(negedge clk);
    n_total++;
    if (bus.oStall !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.oStall);
    else n_pass++;
    n_total++;
    if (bus.oBusy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.oBusy);
    else n_pass++;
    outs = {bus.oCSRWe, bus.oRedirect, 6'b0};
    n_total++;
    if (outs !== 8'h00 || bus.oCSRAddr !== 12'h0 || bus.oCSRWData !== 32'h0 ||
        bus.oRedirectPC !== 32'h0)
      $display("FAIL reset_outputs we=%b rd=%b addr=%h data=%h rpc=%h want all 0",
               bus.oCSRWe, bus.oRedirect, bus.oCSRAddr, bus.oCSRWData, bus.oRedirectPC);
    else n_pass++;
    @(posedge clk); #1; clear_in(); rst = 0;
    @(negedge clk);
    n_total++;
    if (bus.oBusy !== 1'b0) $display("FAIL reset_release_busy got=%b want=0", bus.oBusy);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] c0; logic s; bit ok; ev_t e, o;
    bus.iUTVEC = 32'h0000_0203;
    accept(5'b01000, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, c0, s);
    push_trap(c0, 32'h40, 32'd2, 32'hFFFF_FFFF, 32'h0000_0200);
    n_total++;
    if (s !== 1'b1) $display("FAIL illegal_stall_c0 got=%b want=1", s); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_in();
      @(negedge clk);
      n_total++;
      if (bus.oStall !== (k < 4))
        $display("FAIL illegal_stall_c%0d got=%b want=%b", k, bus.oStall, (k < 4));
      else n_pass++;
    end
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1 || cyc !== c0 + 5)
      $display("FAIL illegal_idle ok=%b cyc=%0d want cyc=%0d", ok, cyc, c0 + 5);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL illegal_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL illegal_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL illegal_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_priority();
    logic [4:0]  fl[4]   = '{5'b01010, 5'b00001, 5'b11111, 5'b00101};
    logic [31:0] pcs[4]  = '{32'h80, 32'h84, 32'h88, 32'h8C};
    logic [31:0] adr[4]  = '{32'h1001, 32'h1002, 32'h1003, 32'h1004};
    logic [31:0] cau[4]  = '{32'd2, 32'd6, 32'd0, 32'd8};
    logic [31:0] tvl[4]  = '{32'h1234_5678, 32'h1002, 32'h88, 32'h0};
    logic [31:0] c0; logic s; bit ok; ev_t e, o;
    bus.iUTVEC = 32'h0000_0301;
    for (int i = 0; i < 4; i++) begin
      accept(fl[i], 1'b0, pcs[i], 32'h1234_5678, adr[i], c0, s);
      push_trap(c0, pcs[i], cau[i], tvl[i], 32'h0000_0300);
      @(posedge clk); #1; clear_in();
      wait_idle(ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL prio_idle_%0d timeout got busy=%b want 0", i, bus.oBusy);
      else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL prio_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL prio_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL prio_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0; logic s; ev_t e, o;
    bus.iUTVEC = 32'h0000_0200; bus.iUEPC = 32'h0000_0104;
    accept(5'b00100, 1'b0, 32'h100, 32'h0000_0073, 32'h0, c0, s);
    push_trap(c0, 32'h100, 32'd8, 32'h0, 32'h0000_0200);
    @(posedge clk); #1; clear_in();
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus.iValid = 1; bus.iUret = 1;
    @(negedge clk);
    n_total++;
    if (bus.oStall !== 1'b1 || bus.oBusy !== 1'b0 || cyc !== c0 + 5)
      $display("FAIL b2b_uret_accept stall=%b busy=%b cyc=%0d want 1 0 %0d",
               bus.oStall, bus.oBusy, cyc, c0 + 5);
    else n_pass++;
    exp_q.push_back(mk_ev(1'b1, 12'h000, 32'h0000_0104, c0 + 6));
    @(posedge clk); #1; clear_in();
    @(negedge clk);
    n_total++;
    if (bus.oStall !== 1'b0 || bus.oCSRWe !== 1'b0)
      $display("FAIL b2b_retjmp stall=%b we=%b want 0 0", bus.oStall, bus.oCSRWe);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.oBusy !== 1'b0) $display("FAIL b2b_ret_idle got busy=%b want 0", bus.oBusy);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL b2b_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL b2b_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_exc_and_uret();
    logic [31:0] c0; logic s; bit ok; ev_t e, o;
    bus.iUTVEC = 32'h0000_0404; bus.iUEPC = 32'hDEAD_0000;
    accept(5'b01000, 1'b1, 32'h200, 32'h0000_ABCD, 32'h0, c0, s);
    push_trap(c0, 32'h200, 32'd2, 32'h0000_ABCD, 32'h0000_0404);
    @(posedge clk); #1; clear_in();
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1 || cyc !== c0 + 5)
      $display("FAIL excuret_idle ok=%b cyc=%0d want cyc=%0d", ok, cyc, c0 + 5);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL excuret_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL excuret_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL excuret_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] c0; logic s; bit ok; ev_t e, o;
    bus.iUTVEC = 32'h0000_0500;
    accept(5'b01000, 1'b0, 32'h300, 32'h0000_0077, 32'h0, c0, s);
    exp_q.push_back(mk_ev(1'b0, 12'h041, 32'h300, c0 + 1));
    @(posedge clk); #1; clear_in();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    n_total++;
    if (bus.oBusy !== 1'b0 || bus.oStall !== 1'b0 || bus.oCSRWe !== 1'b0 ||
        bus.oRedirect !== 1'b0 || bus.oCSRAddr !== 12'h0 || bus.oCSRWData !== 32'h0 ||
        bus.oRedirectPC !== 32'h0)
      $display("FAIL rstmid_outputs busy=%b stall=%b we=%b rd=%b addr=%h data=%h want all 0",
               bus.oBusy, bus.oStall, bus.oCSRWe, bus.oRedirect, bus.oCSRAddr, bus.oCSRWData);
    else n_pass++;
    accept(5'b00100, 1'b0, 32'h400, 32'h0, 32'h0, c0, s);
    push_trap(c0, 32'h400, 32'd8, 32'h0, 32'h0000_0500);
    @(posedge clk); #1; clear_in();
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1 || s !== 1'b1)
      $display("FAIL rstmid_reaccept ok=%b stall=%b want 1 1", ok, s);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL rstmid_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rstmid_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL rstmid_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_ignore_inputs();
    logic [31:0] c0; logic s; bit ok; ev_t e, o; logic [5:0] r;
    bus.iUTVEC = 32'h0000_0600; bus.iUEPC = 32'h0000_0BAD;
    accept(5'b00001, 1'b0, 32'h700, 32'h0, 32'h2222, c0, s);
    push_trap(c0, 32'h700, 32'd6, 32'h2222, 32'h0000_0600);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      r = 6'($urandom_range(1, 63));
      bus.iValid = 1; bus.iPC = $urandom; bus.iInst = $urandom; bus.iAddr = $urandom;
      bus.iMisFetch = r[5]; bus.iIllegal = r[4]; bus.iEcall = r[3];
      bus.iMisLoad = r[2]; bus.iMisStore = r[1]; bus.iUret = r[0];
    end
    @(posedge clk); #1; clear_in();
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL ignore_idle timeout busy=%b want 0", bus.oBusy);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL ignore_seq missing addr=%h data=%h", e.addr, e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL ignore_seq got k=%b a=%h d=%h c=%0d want k=%b a=%h d=%h c=%0d",
                              o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() != 0) begin
      $display("FAIL ignore_extra got=%0d events want 0", obs_q.size()); obs_q.delete();
    end else n_pass++;
    n_total++;
    if (viol !== 0) $display("FAIL output_invariants got=%0d violations want 0", viol);
    else n_pass++;
  endtask

  initial begin
    clear_in();
    bus.iUTVEC = 0; bus.iUEPC = 0;
    test_reset();
    test_illegal();
    test_priority();
    test_back_to_back();
    test_exc_and_uret();
    test_reset_mid();
    test_ignore_inputs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Synchronous-exception front end for the user-mode CSR file in the RISC-V core. It watches the instruction at commit, picks the highest-priority exception, and freezes the pipeline. It then drives the CSR write port with uepc, ucause and utval in a fixed sequence and redirects fetch to utvec. It also handles `uret` by redirecting fetch to uepc.

## Interface
- `XLEN`, 32, data/address width
- `CSRW`, 12, CSR address width

- `iCLK`  in  1  core clock; all state changes on rising edge
- `iRST`  in  1  reset, synchronous, active-high
- `iValid`  in  1  commit-stage instruction valid
- `iPC`  in  XLEN  PC of commit-stage instruction
- `iInst`  in  32  instruction word
- `iAddr`  in  XLEN  effective load/store address
- `iMisFetch`, `iIllegal`, `iEcall`, `iMisLoad`, `iMisStore`  in  1 each  exception flags, qualified by `iValid`
- `iUret`  in  1  commit-stage instruction is `uret`
- `iUTVEC`  in  XLEN  current utvec value from CSR file
- `iUEPC`  in  XLEN  current uepc value from CSR file
- `oStall`  out  1  freeze fetch/decode/commit
- `oCSRWe`  out  1  CSR write strobe
- `oCSRAddr`  out  CSRW  CSR write address
- `oCSRWData`  out  XLEN  CSR write data
- `oRedirect`  out  1  one-cycle fetch redirect strobe
- `oRedirectPC`  out  XLEN  redirect target
- `oBusy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, TRAP_JMP, RET_JMP.
- Accept in IDLE only. Exception pending = `iValid` & (any flag).
- Priority: MisFetch (cause 0) > Illegal (2) > Ecall (8) > MisStore (6) > MisLoad (4).
- On accept, latch the PC, cause and tval, then go to W_EPC.
- tval rules:
  - MisFetch: `iPC`.
  - Illegal: `iInst`.
  - MisLoad/MisStore: `iAddr`.
  - Ecall: 0.
- W_EPC: `oCSRWe`=1, addr 0x041, data = latched PC.
- W_CAUSE: `oCSRWe`=1, addr 0x042, data = cause zero-extended to XLEN.
- W_TVAL: `oCSRWe`=1, addr 0x043, data = tval.
- TRAP_JMP: `oRedirect`=1, `oRedirectPC` = {`iUTVEC`[XLEN-1:2], 2'b00}, sampled in that cycle (direct mode only). Next state IDLE.
- `uret`: in IDLE, `iValid` & `iUret` & no exception → RET_JMP. RET_JMP drives `oRedirect`=1, `oRedirectPC` = `iUEPC` sampled that cycle. Next state IDLE. No CSR writes.
- Exception and `iUret` in the same cycle: the exception wins and `uret` is discarded.
- All inputs are ignored outside IDLE; the pipeline is stalled, so no event can be lost.
- `oCSRAddr`/`oCSRWData` = 0 whenever `oCSRWe`=0. `oRedirectPC` = 0 whenever `oRedirect`=0.

## Timing
- Reset values:
  - State IDLE.
  - `oStall`, `oCSRWe`, `oRedirect`, `oBusy` = 0.
  - `oCSRAddr`, `oCSRWData`, `oRedirectPC` = 0.
  - Latches cleared.
- `oStall` is combinational in IDLE: high in the same cycle an exception or `uret` is accepted. It is high in W_EPC, W_CAUSE and W_TVAL. It is low in TRAP_JMP and RET_JMP so the redirect takes effect on the next edge.
- Exception latency, counting the accept cycle as cycle 0:
  - uepc written at edge ending cycle 1.
  - ucause at end of cycle 2.
  - utval at end of cycle 3.
  - Redirect in cycle 4.
  - IDLE in cycle 5.
- `uret` latency: redirect in cycle 1, IDLE in cycle 2.
- Back-to-back: a new exception can be accepted in the first IDLE cycle after TRAP_JMP or RET_JMP.
- Reset mid-sequence: the FSM returns to IDLE on the next edge. A partially completed write sequence is abandoned and no further writes are issued; software-visible CSR contents are whatever the CSR file holds.
- `oCSRWe` is never high for more than three consecutive cycles. `oRedirect` is never high for more than one cycle.

## Structure
- Shared package/include (`Parametros.v`):
  - cause codes CAUSE_MISFETCH=0, CAUSE_ILLEGAL=2, CAUSE_ECALL=8, CAUSE_MISLOAD=4, CAUSE_MISSTORE=6.
  - CSR addresses UTVEC=0x005, UEPC=0x041, UCAUSE=0x042, UTVAL=0x043.
  - FSM state encoding.
- One natural sub-module: `trap_priority_enc`, a combinational flag → {valid, cause, tval-select} encoder. The FSM and output registers live in the top.

## Test plan
- Illegal, `iPC`=0x0000_0040, `iInst`=0xFFFF_FFFF, `iUTVEC`=0x0000_0203 → writes (0x041, 0x40), (0x042, 2), (0x043, 0xFFFF_FFFF) on cycles 1–3; redirect to 0x0000_0200 in cycle 4; `oStall` high in cycles 0–3.
- MisLoad+Illegal together, `iAddr`=0x1001 → cause 2, tval = `iInst` (priority); MisStore alone with `iAddr`=0x1002 → cause 6, tval 0x1002.
- Ecall at PC 0x100 → cause 8, tval 0; then `uret` with `iUEPC`=0x104 in the first IDLE cycle → redirect to 0x104 one cycle later, no `oCSRWe`.
- Exception and `iUret` in the same cycle → exception sequence only; the RET_JMP state is never entered.
- `iRST` asserted during W_CAUSE → next cycle all outputs 0, state IDLE, no utval write; an exception presented after reset is accepted normally.
- Exception flags toggled while in W_EPC..TRAP_JMP → ignored; exactly three CSR writes and one redirect.
